// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and a held product.
// Optional build macro MULT_ZERO_EARLY_EN: zero operands skip the iterations and finish in one clock.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 listo,
  output logic                 ocupado
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic            q_prev;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc_sum_c;

  // Booth add/subtract step chosen by the current multiplier bit pair
  always_comb begin
    acc_sum_c = acc;
    case ({mplier[0], q_prev})
      2'b10:   acc_sum_c = acc - mcand;
      2'b01:   acc_sum_c = acc + mcand;
      default: acc_sum_c = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      q_prev   <= 1'b0;
      cnt      <= '0;
      producto <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (inicio) begin
            acc     <= '0;
            mcand   <= {multiplicando[WIDTH-1], multiplicando};
            mplier  <= multiplicador;
            q_prev  <= 1'b0;
            cnt     <= CW'(WIDTH);
            ocupado <= 1'b1;
`ifdef MULT_ZERO_EARLY_EN
            // Clearing Q makes the DONE-cycle readout a zero product directly
            if ((multiplicando == '0) || (multiplicador == '0)) begin
              mplier <= '0;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          // Arithmetic right shift of {A,Q,q-1} after the add/subtract
          acc    <= {acc_sum_c[AW-1], acc_sum_c[AW-1:1]};
          mplier <= {acc_sum_c[0], mplier[WIDTH-1:1]};
          q_prev <= mplier[0];
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          producto <= PW'({acc[WIDTH-1:0], mplier});
          listo    <= 1'b1;
          ocupado  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=4); honours MULT_ZERO_EARLY_EN for zero-operand latency.
module tb_booth_mult_seq;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic [3:0] multiplicando;
  logic [3:0] multiplicador;
  logic [7:0] producto;
  logic       listo;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .inicio        (inicio),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .producto      (producto),
    .listo         (listo),
    .ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: single-cycle inicio, operands scrambled after acceptance
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int exp_lat, input logic [7:0] exp_p);
    int lat;
    @(negedge clk);
    multiplicando = a;
    multiplicador = b;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    multiplicando = ~a;
    multiplicador = ~b;
    chk({tag, "_busy"}, 32'(ocupado), 32'd1);
    chk({tag, "_nolisto0"}, 32'(listo), 32'd0);
    lat = 0;
    while (!listo && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(producto), 32'(exp_p));
    chk({tag, "_idle_at_done"}, 32'(ocupado), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(listo), 32'd0);
    chk({tag, "_held"}, 32'(producto), 32'(exp_p));
  endtask

  initial begin
    int pulses;
    int zero_lat;
    rst = 1'b1;
    inicio = 1'b0;
    multiplicando = 4'd0;
    multiplicador = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_prod", 32'(producto), 32'd0);
    chk("reset_listo", 32'(listo), 32'd0);
    chk("reset_busy", 32'(ocupado), 32'd0);
    rst = 1'b0;

    // 1: idle for 20 clocks with no start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_prod", 32'(producto), 32'd0);
      chk("idle_listo", 32'(listo), 32'd0);
      chk("idle_busy", 32'(ocupado), 32'd0);
    end

    // 2: basic product and hold
    run_op("m3x5", 4'd3, 4'd5, 5, 8'd15);
    repeat (4) @(negedge clk);
    chk("m3x5_hold_long", 32'(producto), 32'd15);

    // 3: signed extremes back to back
    run_op("m8x8", 4'h8, 4'h8, 5, 8'h40);
    run_op("m8x7", 4'h8, 4'h7, 5, 8'hC8);
    run_op("m3x6", 4'hD, 4'h6, 5, 8'hEE);
    run_op("m7x8", 4'h7, 4'h8, 5, 8'hC8);
    run_op("m1x1", 4'hF, 4'hF, 5, 8'h01);

    // 4: second start during CALC is ignored
    @(negedge clk);
    multiplicando = 4'd7;
    multiplicador = 4'd7;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    multiplicando = 4'd2;
    multiplicador = 4'd2;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_prod", 32'(producto), 32'd49);

    // 5: reset mid-CALC aborts
    @(negedge clk);
    multiplicando = 4'd6;
    multiplicador = 4'd6;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_prod", 32'(producto), 32'd0);
    chk("abort_busy", 32'(ocupado), 32'd0);
    chk("abort_listo", 32'(listo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    chk("abort_prod_after", 32'(producto), 32'd0);
    run_op("m2xn4", 4'd2, 4'hC, 5, 8'hF8);

    // 6: zero operand latency depends on build
`ifdef MULT_ZERO_EARLY_EN
    zero_lat = 1;
`else
    zero_lat = 5;
`endif
    run_op("m0xn7", 4'd0, 4'h9, zero_lat, 8'h00);
    run_op("m5x0", 4'd5, 4'd0, zero_lat, 8'h00);
    run_op("m4x3", 4'd4, 4'd3, 5, 8'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
